memory_controller: RTL and testbench
====================================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous reset, active-high
- address  in  32  core byte address
- write_enable  in  1  core write strobe
- data_in_size  in  2  write size
- data_out_size  in  2  read size
- data_in  in  32  core write data
- data_out  out  32  read data to core
- memory_error  out  1  access fault flag
- code_in  in  32  code ROM word at code_address (little-endian)
- code_address  out  32  code ROM byte offset
- memory_in  in  32  RAM read data
- memory_address  out  32  RAM byte offset
- memory_out  out  32  RAM write data
- memory_size  out  2  RAM access size
- memory_write_enable  out  1  RAM write strobe
- input_in  in  32  input port value
- output_in  in  32  output-map read data
- output_address  out  32  output-map byte offset
- output_out  out  32  output-map write data
- output_size  out  2  output-map access size
- output_write_enable  out  1  output-map write strobe

REQ-002 SHALL use one clock (clk); reset SHALL be synchronous and active-high (rst).

Function
REQ-003 Size encoding SHALL be: 00 byte, 01 halfword, 10 word, 11 invalid.
REQ-004 Address decode on address[31:28] SHALL be: 0x0 code (read-only), 0x1 RAM, 0x2 input (read-only), 0x3 output map; any other value is unmapped.
REQ-005 Offsets SHALL be address[27:0] zero-extended to 32 bits, driven to code_address, memory_address and output_address at all times regardless of the selected region.
REQ-006 memory_out and output_out SHALL equal data_in.
REQ-007 memory_size and output_size SHALL equal data_in_size when write_enable=1, else data_out_size.
REQ-008 memory_write_enable SHALL be 1 only for a legal write to the RAM region; output_write_enable SHALL be 1 only for a legal write to the output region.
REQ-009 Read data SHALL be selected by region (code_in, memory_in, input_in, output_in) and masked to the read size: byte keeps [7:0], halfword keeps [15:0], upper bits zero.
REQ-010 An access SHALL be illegal when the active size is 11, the address is misaligned (halfword with address[0]=1, word with address[1:0]!=00), the address is unmapped, or write_enable=1 targets the code or input region.
REQ-011 An illegal access SHALL assert no write strobe and SHALL return data_out=0.
REQ-012 The decode and data path SHALL be purely combinational (zero-cycle latency); only the error state is clocked.

Reset
REQ-013 While rst=1 at a rising clk edge, the registered error state SHALL clear to 0.
REQ-014 While rst=1, both write strobes SHALL be forced to 0.
REQ-015 The combinational read path SHALL remain active during reset.

Configuration
REQ-016 Macro MEMCTRL_STICKY_ERROR_EN: when defined, memory_error SHALL be a register set on the clk edge following any illegal access and held until reset.
REQ-017 When MEMCTRL_STICKY_ERROR_EN is not defined, memory_error SHALL be the combinational illegal-access flag of the current cycle.

Verification
REQ-018 Read address 0x00000004, size 10, code_in=0xDEADBEEF -> code_address=4, data_out=0xDEADBEEF, memory_error=0.
REQ-019 Write address 0x30000000, size 10, data_in=0x000000A5 -> output_write_enable=1, output_address=0, output_out=0xA5, output_size=10.
REQ-020 Read address 0x20000000, size 00, input_in=0x0000ABCD -> data_out=0x000000CD.
REQ-021 Write address 0x10000002, size 10 -> memory_write_enable=0, error raised; with MEMCTRL_STICKY_ERROR_EN, memory_error stays 1 until rst=1, then clears to 0 on the next edge.
REQ-022 Write address 0x00000000 (code region) and read address 0x50000000 (unmapped) -> no write strobe asserted, data_out=0, error raised.

Source files
------------

// File: rtl/memory_controller.sv
// Address-decoding memory controller routing core accesses to code ROM, RAM, input port and output map.
// Optional macro MEMCTRL_STICKY_ERROR_EN makes memory_error a sticky register cleared only by rst.
module memory_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        write_enable,
    input  logic [1:0]  data_in_size,
    input  logic [1:0]  data_out_size,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        memory_error,
    input  logic [31:0] code_in,
    output logic [31:0] code_address,
    input  logic [31:0] memory_in,
    output logic [31:0] memory_address,
    output logic [31:0] memory_out,
    output logic [1:0]  memory_size,
    output logic        memory_write_enable,
    input  logic [31:0] input_in,
    input  logic [31:0] output_in,
    output logic [31:0] output_address,
    output logic [31:0] output_out,
    output logic [1:0]  output_size,
    output logic        output_write_enable
);

    typedef enum logic [1:0] {
        REGION_CODE   = 2'd0,
        REGION_RAM    = 2'd1,
        REGION_INPUT  = 2'd2,
        REGION_OUTPUT = 2'd3
    } region_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [1:0]  active_size;
    logic        mapped;
    region_t     region;
    logic        size_bad;
    logic        misaligned;
    logic        readonly_write;
    logic        illegal;
    logic [31:0] selected;
    logic [31:0] offset;

    assign active_size = write_enable ? data_in_size : data_out_size;
    assign mapped      = (address[31:30] == 2'b00);
    assign region      = region_t'(address[29:28]);
    assign offset      = {4'h0, address[27:0]};

    assign code_address   = offset;
    assign memory_address = offset;
    assign output_address = offset;
    assign memory_out     = data_in;
    assign output_out     = data_in;
    assign memory_size    = active_size;
    assign output_size    = active_size;

    // Classify the current access; any single fault makes the whole access illegal.
    always_comb begin
        size_bad       = (active_size == 2'b11);
        misaligned     = 1'b0;
        readonly_write = 1'b0;
        if (active_size == SIZE_HALF && address[0])
            misaligned = 1'b1;
        if (active_size == SIZE_WORD && address[1:0] != 2'b00)
            misaligned = 1'b1;
        if (write_enable && mapped && (region == REGION_CODE || region == REGION_INPUT))
            readonly_write = 1'b1;
        illegal = size_bad | misaligned | readonly_write | ~mapped;
    end

    assign memory_write_enable = ~rst & write_enable & ~illegal & (region == REGION_RAM);
    assign output_write_enable = ~rst & write_enable & ~illegal & (region == REGION_OUTPUT);

    always_comb begin
        selected = 32'h0;
        case (region)
            REGION_CODE:   selected = code_in;
            REGION_RAM:    selected = memory_in;
            REGION_INPUT:  selected = input_in;
            REGION_OUTPUT: selected = output_in;
            default:       selected = 32'h0;
        endcase
    end

    // Illegal accesses read as zero; narrow reads zero-fill the upper bits.
    always_comb begin
        data_out = 32'h0;
        if (!illegal) begin
            case (active_size)
                SIZE_BYTE: data_out = {24'h0, selected[7:0]};
                SIZE_HALF: data_out = {16'h0, selected[15:0]};
                default:   data_out = selected;
            endcase
        end
    end

`ifdef MEMCTRL_STICKY_ERROR_EN
    logic error_reg;

    always_ff @(posedge clk) begin
        if (rst)
            error_reg <= 1'b0;
        else if (illegal)
            error_reg <= 1'b1;
    end

    assign memory_error = error_reg;
`else
    // Without the sticky option nothing is clocked; clk is intentionally left unconsumed.
    logic unused_clk;
    assign unused_clk   = clk;
    assign memory_error = illegal;
`endif

endmodule

// File: tb/tb_memory_controller.sv
// Directed self-checking bench for memory_controller; expectations adapt to MEMCTRL_STICKY_ERROR_EN.
module tb_memory_controller;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic        write_enable;
    logic [1:0]  data_in_size;
    logic [1:0]  data_out_size;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        memory_error;
    logic [31:0] code_in;
    logic [31:0] code_address;
    logic [31:0] memory_in;
    logic [31:0] memory_address;
    logic [31:0] memory_out;
    logic [1:0]  memory_size;
    logic        memory_write_enable;
    logic [31:0] input_in;
    logic [31:0] output_in;
    logic [31:0] output_address;
    logic [31:0] output_out;
    logic [1:0]  output_size;
    logic        output_write_enable;

    int tests;
    int failures;

    memory_controller dut (
        .clk                 (clk),
        .rst                 (rst),
        .address             (address),
        .write_enable        (write_enable),
        .data_in_size        (data_in_size),
        .data_out_size       (data_out_size),
        .data_in             (data_in),
        .data_out            (data_out),
        .memory_error        (memory_error),
        .code_in             (code_in),
        .code_address        (code_address),
        .memory_in           (memory_in),
        .memory_address      (memory_address),
        .memory_out          (memory_out),
        .memory_size         (memory_size),
        .memory_write_enable (memory_write_enable),
        .input_in            (input_in),
        .output_in           (output_in),
        .output_address      (output_address),
        .output_out          (output_out),
        .output_size         (output_size),
        .output_write_enable (output_write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one access and let the combinational path settle.
    task automatic applyStimulus(input logic [31:0] addr, input logic we,
                                 input logic [1:0] in_size, input logic [1:0] out_size,
                                 input logic [31:0] wdata);
        address       = addr;
        write_enable  = we;
        data_in_size  = in_size;
        data_out_size = out_size;
        data_in       = wdata;
        #1;
    endtask

    task automatic do_reset();
        applyStimulus(32'h1000_0000, 1'b0, 2'b10, 2'b10, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        memory_in = 32'h1234_5678;
        rst = 1'b1;
        applyStimulus(32'h1000_0000, 1'b0, 2'b10, 2'b10, 32'h0);
        @(posedge clk);
        #1;
        tests++;
        if (memory_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_error: got %b expected 0", memory_error);
        end
        tests++;
        if (data_out !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL reset_read_path: got %h expected 12345678", data_out);
        end
        applyStimulus(32'h1000_0000, 1'b1, 2'b10, 2'b10, 32'hAAAA_5555);
        tests++;
        if (memory_write_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ram_strobe: got %b expected 0", memory_write_enable);
        end
        applyStimulus(32'h3000_0000, 1'b1, 2'b10, 2'b10, 32'hAAAA_5555);
        tests++;
        if (output_write_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_strobe: got %b expected 0", output_write_enable);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(32'h1000_0000, 1'b1, 2'b10, 2'b10, 32'hAAAA_5555);
        tests++;
        if (memory_write_enable !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_ram_strobe: got %b expected 1", memory_write_enable);
        end
    endtask

    task automatic test_code_read();
        code_in = 32'hDEAD_BEEF;
        applyStimulus(32'h0000_0004, 1'b0, 2'b00, 2'b10, 32'h0);
        tests++;
        if (code_address !== 32'h4) begin
            failures++;
            $display("[TB] FAIL code_address: got %h expected 00000004", code_address);
        end
        tests++;
        if (data_out !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL code_read: got %h expected deadbeef", data_out);
        end
        @(posedge clk);
        #1;
        tests++;
        if (memory_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL code_read_error: got %b expected 0", memory_error);
        end
    endtask

    task automatic test_output_write();
        applyStimulus(32'h3000_0000, 1'b1, 2'b10, 2'b00, 32'h0000_00A5);
        tests++;
        if (output_write_enable !== 1'b1) begin
            failures++;
            $display("[TB] FAIL out_strobe: got %b expected 1", output_write_enable);
        end
        tests++;
        if (memory_write_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL out_ram_strobe: got %b expected 0", memory_write_enable);
        end
        tests++;
        if (output_address !== 32'h0 || output_out !== 32'hA5 || output_size !== 2'b10) begin
            failures++;
            $display("[TB] FAIL out_write_bus: got addr=%h data=%h size=%b expected 00000000 000000a5 10",
                     output_address, output_out, output_size);
        end
        output_in = 32'h55AA_33CC;
        applyStimulus(32'h3000_000C, 1'b0, 2'b00, 2'b10, 32'h0);
        tests++;
        if (data_out !== 32'h55AA_33CC || output_address !== 32'hC || output_write_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL out_read: got data=%h addr=%h we=%b expected 55aa33cc 0000000c 0",
                     data_out, output_address, output_write_enable);
        end
    endtask

    task automatic test_input_read();
        input_in = 32'h0000_ABCD;
        applyStimulus(32'h2000_0000, 1'b0, 2'b10, 2'b00, 32'h0);
        tests++;
        if (data_out !== 32'h0000_00CD) begin
            failures++;
            $display("[TB] FAIL input_byte: got %h expected 000000cd", data_out);
        end
        input_in = 32'h1234_ABCD;
        applyStimulus(32'h2000_0002, 1'b0, 2'b10, 2'b01, 32'h0);
        tests++;
        if (data_out !== 32'h0000_ABCD) begin
            failures++;
            $display("[TB] FAIL input_half: got %h expected 0000abcd", data_out);
        end
    endtask

    task automatic test_ram();
        applyStimulus(32'h1000_0010, 1'b1, 2'b10, 2'b00, 32'h1122_3344);
        tests++;
        if (memory_write_enable !== 1'b1 || memory_out !== 32'h1122_3344 ||
            memory_size !== 2'b10 || memory_address !== 32'h10) begin
            failures++;
            $display("[TB] FAIL ram_write: got we=%b data=%h size=%b addr=%h expected 1 11223344 10 00000010",
                     memory_write_enable, memory_out, memory_size, memory_address);
        end
        memory_in = 32'hCAFE_F00D;
        applyStimulus(32'h1000_0006, 1'b0, 2'b10, 2'b01, 32'h0);
        tests++;
        if (data_out !== 32'h0000_F00D || memory_size !== 2'b01 || memory_write_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ram_half_read: got data=%h size=%b we=%b expected 0000f00d 01 0",
                     data_out, memory_size, memory_write_enable);
        end
        applyStimulus(32'h1000_0003, 1'b1, 2'b00, 2'b10, 32'h0000_0077);
        tests++;
        if (memory_write_enable !== 1'b1 || memory_size !== 2'b00) begin
            failures++;
            $display("[TB] FAIL ram_byte_write: got we=%b size=%b expected 1 00",
                     memory_write_enable, memory_size);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        applyStimulus(32'h1000_0002, 1'b1, 2'b10, 2'b00, 32'hFFFF_FFFF);
        tests++;
        if (memory_write_enable !== 1'b0 || data_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL misaligned_write: got we=%b data=%h expected 0 00000000",
                     memory_write_enable, data_out);
        end
        @(posedge clk);
        #1;
        tests++;
        if (memory_error !== 1'b1) begin
            failures++;
            $display("[TB] FAIL misaligned_error: got %b expected 1", memory_error);
        end
        applyStimulus(32'h1000_0000, 1'b0, 2'b10, 2'b10, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++;
`ifdef MEMCTRL_STICKY_ERROR_EN
        if (memory_error !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sticky_hold: got %b expected 1", memory_error);
        end
`else
        if (memory_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL error_follows_access: got %b expected 0", memory_error);
        end
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (memory_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL error_clear_after_reset: got %b expected 0", memory_error);
        end
        applyStimulus(32'h3000_0001, 1'b0, 2'b10, 2'b01, 32'h0);
        tests++;
        if (data_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL misaligned_half_read: got %h expected 00000000", data_out);
        end
        @(posedge clk);
        #1;
        tests++;
        if (memory_error !== 1'b1) begin
            failures++;
            $display("[TB] FAIL misaligned_half_error: got %b expected 1", memory_error);
        end
    endtask

    task automatic test_illegal();
        code_in   = 32'h0BAD_C0DE;
        memory_in = 32'h7777_7777;
        input_in  = 32'h5A5A_5A5A;
        do_reset();
        applyStimulus(32'h0000_0000, 1'b1, 2'b10, 2'b10, 32'h1234_5678);
        tests++;
        if (memory_write_enable !== 1'b0 || output_write_enable !== 1'b0 || data_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL code_write: got mwe=%b owe=%b data=%h expected 0 0 00000000",
                     memory_write_enable, output_write_enable, data_out);
        end
        @(posedge clk);
        #1;
        tests++;
        if (memory_error !== 1'b1) begin
            failures++;
            $display("[TB] FAIL code_write_error: got %b expected 1", memory_error);
        end
        do_reset();
        applyStimulus(32'h5000_0000, 1'b0, 2'b10, 2'b10, 32'h0);
        tests++;
        if (data_out !== 32'h0 || memory_write_enable !== 1'b0 || output_write_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL unmapped_read: got data=%h mwe=%b owe=%b expected 00000000 0 0",
                     data_out, memory_write_enable, output_write_enable);
        end
        @(posedge clk);
        #1;
        tests++;
        if (memory_error !== 1'b1) begin
            failures++;
            $display("[TB] FAIL unmapped_error: got %b expected 1", memory_error);
        end
        do_reset();
        applyStimulus(32'h1000_0000, 1'b0, 2'b10, 2'b11, 32'h0);
        tests++;
        if (data_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL invalid_size_read: got %h expected 00000000", data_out);
        end
        applyStimulus(32'h1000_0000, 1'b1, 2'b11, 2'b10, 32'h0);
        tests++;
        if (memory_write_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL invalid_size_write: got %b expected 0", memory_write_enable);
        end
        applyStimulus(32'h2000_0000, 1'b1, 2'b10, 2'b10, 32'h0);
        @(posedge clk);
        #1;
        tests++;
        if (memory_error !== 1'b1 || memory_write_enable !== 1'b0 || output_write_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL input_write: got err=%b mwe=%b owe=%b expected 1 0 0",
                     memory_error, memory_write_enable, output_write_enable);
        end
    endtask

    initial begin
        tests         = 0;
        failures      = 0;
        rst           = 1'b1;
        address       = 32'h0;
        write_enable  = 1'b0;
        data_in_size  = 2'b10;
        data_out_size = 2'b10;
        data_in       = 32'h0;
        code_in       = 32'h0;
        memory_in     = 32'h0;
        input_in      = 32'h0;
        output_in     = 32'h0;
        @(negedge clk);
        test_reset();
        test_code_read();
        test_output_write();
        test_input_read();
        test_ram();
        test_misaligned();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
